// File: rtl/dx_pkg.sv
// Shared definitions for the decode/execute operand stage: operand and
// register-index widths, the hard-wired zero register and the ALU opcodes.
package dx_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [4:0] {
      OP_ADD = 5'd0,
      OP_SUB = 5'd1,
      OP_AND = 5'd2,
      OP_OR  = 5'd3,
      OP_SLL = 5'd4,
      OP_SRA = 5'd5
   } alu_op_e;

   // Highest opcode the ALU decodes; anything above leaves its result bus undriven.
   localparam logic [4:0] OP_MAX = 5'd5;

endpackage

// File: rtl/dx_operand_stage_bypass_mux.sv
// operand_bypass_mux: resolves one source operand against the two younger
// writers in flight. X/M is the newer result and wins over M/W; register 0
// is hard-wired and never forwarded.
module operand_bypass_mux
   import dx_pkg::*;
(
   input  logic [REG_W-1:0]  idx,
   input  logic [DATA_W-1:0] raw_data,
   input  logic              xm_wr_en,
   input  logic [REG_W-1:0]  xm_rd_idx,
   input  logic [DATA_W-1:0] xm_data,
   input  logic              mw_wr_en,
   input  logic [REG_W-1:0]  mw_rd_idx,
   input  logic [DATA_W-1:0] mw_data,
   output logic [DATA_W-1:0] data
);

   // Priority select: zero register, then X/M, then M/W, then register file.
   always_comb begin
      data = raw_data;
      if (idx == REG_ZERO) begin
         data = raw_data;
      end else if (xm_wr_en && (xm_rd_idx == idx)) begin
         data = xm_data;
      end else if (mw_wr_en && (mw_rd_idx == idx)) begin
         data = mw_data;
      end
   end

endmodule

// File: rtl/dx_operand_stage.sv
// dx_operand_stage: single-entry D/X pipeline register in front of the ALU.
// Resolves operands, sanitises the opcode and hands a registered operation
// to execute over a valid/ready handshake, with flush support.
// Build option DX_BYPASS_EN: when defined, operands are forwarded from X/M
// and M/W; when undefined, operands are taken raw and a hazard interlock
// stalls decode instead.
module dx_operand_stage
   import dx_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_rs_idx,
   input  logic [REG_W-1:0]  in_rt_idx,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   input  logic [4:0]        in_aluop,
   input  logic [4:0]        in_shamt,
   input  logic [REG_W-1:0]  in_rd_idx,
   input  logic              in_wr_en,
   input  logic              xm_wr_en,
   input  logic [REG_W-1:0]  xm_rd_idx,
   input  logic [DATA_W-1:0] xm_data,
   input  logic              mw_wr_en,
   input  logic [REG_W-1:0]  mw_rd_idx,
   input  logic [DATA_W-1:0] mw_data,
   output logic [DATA_W-1:0] data_operandA,
   output logic [DATA_W-1:0] data_operandB,
   output logic [4:0]        ctrl_ALUopcode,
   output logic [4:0]        ctrl_shiftamt,
   output logic [REG_W-1:0]  out_rd_idx,
   output logic              out_wr_en,
   output logic              out_illegal,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  issued_count
);

   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [4:0]        op_q, op_d, shamt_q, shamt_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic              wr_en_q, wr_en_d, illegal_q, illegal_d, valid_q, valid_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DATA_W-1:0] res_a, res_b;
   logic              fwd_xm_en, fwd_mw_en, hazard;
   logic              in_fire, out_fire, op_illegal;

`ifdef DX_BYPASS_EN
   assign fwd_xm_en = xm_wr_en;
   assign fwd_mw_en = mw_wr_en;
   assign hazard    = 1'b0;
`else
   // Without forwarding the muxes degenerate to the raw register value, and
   // decode must wait until no in-flight writer targets a live source.
   assign fwd_xm_en = 1'b0;
   assign fwd_mw_en = 1'b0;
   assign hazard = in_valid && (
        (xm_wr_en && (xm_rd_idx != REG_ZERO) &&
           ((xm_rd_idx == in_rs_idx) || (!in_use_imm && (xm_rd_idx == in_rt_idx))))
     || (mw_wr_en && (mw_rd_idx != REG_ZERO) &&
           ((mw_rd_idx == in_rs_idx) || (!in_use_imm && (mw_rd_idx == in_rt_idx)))));
`endif

   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = valid_q && out_ready;

   operand_bypass_mux u_bypass_a (
      .idx       (in_rs_idx),
      .raw_data  (in_rs_data),
      .xm_wr_en  (fwd_xm_en),
      .xm_rd_idx (xm_rd_idx),
      .xm_data   (xm_data),
      .mw_wr_en  (fwd_mw_en),
      .mw_rd_idx (mw_rd_idx),
      .mw_data   (mw_data),
      .data      (res_a)
   );

   operand_bypass_mux u_bypass_b (
      .idx       (in_rt_idx),
      .raw_data  (in_rt_data),
      .xm_wr_en  (fwd_xm_en),
      .xm_rd_idx (xm_rd_idx),
      .xm_data   (xm_data),
      .mw_wr_en  (fwd_mw_en),
      .mw_rd_idx (mw_rd_idx),
      .mw_data   (mw_data),
      .data      (res_b)
   );

   // Capture a new operation on input transfer and compute valid/counter next state.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      shamt_d    = shamt_q;
      rd_d       = rd_q;
      wr_en_d    = wr_en_q;
      illegal_d  = illegal_q;
      valid_d    = valid_q;
      count_d    = count_q;
      op_illegal = (in_aluop > OP_MAX);

      if (in_fire) begin
         a_d       = res_a;
         b_d       = in_use_imm ? in_imm : res_b;
         op_d      = op_illegal ? OP_ADD : in_aluop;
         shamt_d   = in_shamt;
         rd_d      = in_rd_idx;
         wr_en_d   = in_wr_en && !op_illegal;
         illegal_d = op_illegal;
      end

      if (flush) begin
         valid_d = 1'b0;
      end else if (in_fire) begin
         valid_d = 1'b1;
      end else if (out_fire) begin
         valid_d = 1'b0;
      end

      if (out_fire && !flush && (count_q != '1)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Pipeline register with immediate clear on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         shamt_q   <= '0;
         rd_q      <= '0;
         wr_en_q   <= 1'b0;
         illegal_q <= 1'b0;
         valid_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         shamt_q   <= shamt_d;
         rd_q      <= rd_d;
         wr_en_q   <= wr_en_d;
         illegal_q <= illegal_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   assign data_operandA  = a_q;
   assign data_operandB  = b_q;
   assign ctrl_ALUopcode = op_q;
   assign ctrl_shiftamt  = shamt_q;
   assign out_rd_idx     = rd_q;
   assign out_wr_en      = wr_en_q;
   assign out_illegal    = illegal_q;
   assign out_valid      = valid_q;
   assign issued_count   = count_q;

endmodule

// File: tb/tb_dx_operand_stage.sv
// Testbench for dx_operand_stage. A scoreboard queue holds the operations the
// stage should currently contain; entries are pushed on input transfer and
// popped and compared on output transfer. Follows DX_BYPASS_EN like the RTL.
module tb_dx_operand_stage;
   import dx_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        wr;
      logic        ill;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [4:0]  in_rs_idx, in_rt_idx, in_aluop, in_shamt, in_rd_idx;
   logic [31:0] in_rs_data, in_rt_data, in_imm;
   logic        in_use_imm, in_wr_en;
   logic        xm_wr_en, mw_wr_en;
   logic [4:0]  xm_rd_idx, mw_rd_idx;
   logic [31:0] xm_data, mw_data;
   logic [31:0] data_operandA, data_operandB;
   logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt, out_rd_idx;
   logic        out_wr_en, out_illegal, out_valid, out_ready;
   logic [31:0] issued_count;

   int          tests_run = 0;
   int          tests_failed = 0;
   exp_t        sb[$];
   logic [31:0] exp_cnt = 0;

   always #5 clock = ~clock;

   dx_operand_stage #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_aluop(in_aluop), .in_shamt(in_shamt),
      .in_rd_idx(in_rd_idx), .in_wr_en(in_wr_en),
      .xm_wr_en(xm_wr_en), .xm_rd_idx(xm_rd_idx), .xm_data(xm_data),
      .mw_wr_en(mw_wr_en), .mw_rd_idx(mw_rd_idx), .mw_data(mw_data),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
      .out_rd_idx(out_rd_idx), .out_wr_en(out_wr_en),
      .out_illegal(out_illegal), .out_valid(out_valid),
      .out_ready(out_ready), .issued_count(issued_count)
   );

   // Reference operand resolution for one source.
   function automatic logic [31:0] model_bypass(input logic [4:0] idx, input logic [31:0] raw);
`ifdef DX_BYPASS_EN
      if (idx == 5'd0) return raw;
      if (xm_wr_en && xm_rd_idx == idx) return xm_data;
      if (mw_wr_en && mw_rd_idx == idx) return mw_data;
      return raw;
`else
      return raw;
`endif
   endfunction

   // Reference interlock: only present when forwarding is compiled out.
   function automatic logic model_hazard();
`ifdef DX_BYPASS_EN
      return 1'b0;
`else
      logic xm_hit, mw_hit;
      xm_hit = xm_wr_en && xm_rd_idx != 5'd0 &&
               (xm_rd_idx == in_rs_idx || (!in_use_imm && xm_rd_idx == in_rt_idx));
      mw_hit = mw_wr_en && mw_rd_idx != 5'd0 &&
               (mw_rd_idx == in_rs_idx || (!in_use_imm && mw_rd_idx == in_rt_idx));
      return in_valid && (xm_hit || mw_hit);
`endif
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      e.ill   = (in_aluop > 5'd5);
      e.a     = model_bypass(in_rs_idx, in_rs_data);
      e.b     = in_use_imm ? in_imm : model_bypass(in_rt_idx, in_rt_data);
      e.op    = e.ill ? 5'd0 : in_aluop;
      e.shamt = in_shamt;
      e.rd    = in_rd_idx;
      e.wr    = in_wr_en && !e.ill;
      return e;
   endfunction

   task automatic applyStimulus(input logic [4:0] rs, input logic [31:0] rs_d,
                                input logic [4:0] rt, input logic [31:0] rt_d,
                                input logic [31:0] imm, input logic use_imm,
                                input logic [4:0] op, input logic [4:0] sh,
                                input logic [4:0] rd, input logic wr);
      in_rs_idx = rs;  in_rs_data = rs_d;
      in_rt_idx = rt;  in_rt_data = rt_d;
      in_imm = imm;    in_use_imm = use_imm;
      in_aluop = op;   in_shamt = sh;
      in_rd_idx = rd;  in_wr_en = wr;
   endtask

   // One clock of scoreboard activity: check handshake, retire/accept, advance.
   task automatic drive_cycle();
      logic exp_ready, in_fire, out_fire;
      exp_t e, act;
      #1;
      exp_ready = ((sb.size() == 0) || out_ready) && !model_hazard();
      tests_run++;
      if (in_ready !== exp_ready) begin
         tests_failed++;
         $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
      end
      in_fire  = in_valid && exp_ready;
      out_fire = (sb.size() != 0) && out_ready;
      if (out_fire) begin
         e   = sb.pop_front();
         act = {data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
                out_rd_idx, out_wr_en, out_illegal};
         tests_run++;
         if (act !== e) begin
            tests_failed++;
            $display("[TB] FAIL transfer: got A=%h B=%h op=%0d sh=%0d rd=%0d wr=%b ill=%b expected A=%h B=%h op=%0d sh=%0d rd=%0d wr=%b ill=%b",
                     act.a, act.b, act.op, act.shamt, act.rd, act.wr, act.ill,
                     e.a, e.b, e.op, e.shamt, e.rd, e.wr, e.ill);
         end
      end
      if (out_fire && !flush) exp_cnt++;
      if (flush) sb.delete();
      else if (in_fire) sb.push_back(model_expect());
      @(posedge clock);
      #1;
      tests_run++;
      if (out_valid !== (sb.size() != 0)) begin
         tests_failed++;
         $display("[TB] FAIL out_valid: got %b expected %b at %0t", out_valid, (sb.size() != 0), $time);
      end
      tests_run++;
      if (issued_count !== exp_cnt) begin
         tests_failed++;
         $display("[TB] FAIL issued_count: got %0d expected %0d", issued_count, exp_cnt);
      end
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if ({out_valid, out_illegal, out_wr_en} !== 3'b000 || issued_count !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got valid=%b ill=%b wr=%b cnt=%0d expected 0", out_valid, out_illegal, out_wr_en, issued_count);
      end
      tests_run++;
      if ({data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_rd_idx} !== 79'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_data: got A=%h B=%h op=%0d expected 0", data_operandA, data_operandB, ctrl_ALUopcode);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive_cycle();
   endtask

   task automatic test_basic_issue();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      applyStimulus(5'd3, 32'h10, 5'd4, 32'h5, 32'h0, 1'b0, 5'd0, 5'd2, 5'd8, 1'b1);
      drive_cycle();
      in_valid = 1'b0;
      tests_run++;
      if (data_operandA !== 32'h10 || data_operandB !== 32'h5 || ctrl_ALUopcode !== 5'd0 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL basic_issue: got A=%h B=%h op=%0d v=%b expected A=10 B=5 op=0 v=1", data_operandA, data_operandB, ctrl_ALUopcode, out_valid);
      end
      drive_cycle();
      tests_run++;
      if (issued_count !== 32'd1) begin
         tests_failed++;
         $display("[TB] FAIL basic_count: got %0d expected 1", issued_count);
      end
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      xm_wr_en = 1'b1; xm_rd_idx = 5'd7; xm_data = 32'hAAAA_AAAA;
      mw_wr_en = 1'b1; mw_rd_idx = 5'd7; mw_data = 32'h5555_5555;
      applyStimulus(5'd7, 32'h1234_0007, 5'd0, 32'h0, 32'h99, 1'b1, 5'd1, 5'd0, 5'd9, 1'b1);
      drive_cycle();
`ifdef DX_BYPASS_EN
      tests_run++;
      if (data_operandA !== 32'hAAAA_AAAA) begin
         tests_failed++;
         $display("[TB] FAIL bypass_xm: got %h expected aaaaaaaa", data_operandA);
      end
`endif
      xm_wr_en = 1'b0;
      drive_cycle();
`ifdef DX_BYPASS_EN
      tests_run++;
      if (data_operandA !== 32'h5555_5555) begin
         tests_failed++;
         $display("[TB] FAIL bypass_mw: got %h expected 55555555", data_operandA);
      end
`endif
      xm_wr_en = 1'b1; xm_rd_idx = 5'd0; mw_rd_idx = 5'd0;
      applyStimulus(5'd0, 32'hDEAD_0000, 5'd7, 32'h77, 32'h0, 1'b0, 5'd2, 5'd1, 5'd10, 1'b1);
      drive_cycle();
      tests_run++;
      if (data_operandA !== 32'hDEAD_0000) begin
         tests_failed++;
         $display("[TB] FAIL bypass_r0: got %h expected dead0000", data_operandA);
      end
      in_valid = 1'b0;
      xm_wr_en = 1'b0; mw_wr_en = 1'b0;
      drive_cycle();
   endtask

   task automatic test_back_to_back();
      logic [80:0] held;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      applyStimulus(5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1);
      drive_cycle();
      held = {data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_rd_idx, out_wr_en, out_illegal};
      applyStimulus(5'd6, 32'h66, 5'd7, 32'h77, 32'h0, 1'b0, 5'd4, 5'd9, 5'd11, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive_cycle();
         tests_run++;
         if ({data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_rd_idx, out_wr_en, out_illegal} !== held) begin
            tests_failed++;
            $display("[TB] FAIL stall_stable: got A=%h expected A=%h", data_operandA, held[80:49]);
         end
      end
      out_ready = 1'b1;
      drive_cycle();
      applyStimulus(5'd8, 32'h88, 5'd9, 32'h99, 32'h0, 1'b0, 5'd5, 5'd31, 5'd12, 1'b0);
      drive_cycle();
      tests_run++;
      if (out_valid !== 1'b1 || data_operandA !== 32'h88) begin
         tests_failed++;
         $display("[TB] FAIL no_bubble: got v=%b A=%h expected v=1 A=88", out_valid, data_operandA);
      end
      in_valid = 1'b0;
      drive_cycle();
   endtask

   task automatic test_flush();
      logic [31:0] cnt_before;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      applyStimulus(5'd2, 32'h2, 5'd3, 32'h3, 32'h0, 1'b0, 5'd2, 5'd0, 5'd4, 1'b1);
      drive_cycle();
      cnt_before = issued_count;
      out_ready = 1'b1;
      flush = 1'b1;
      applyStimulus(5'd4, 32'h4, 5'd5, 32'h5, 32'h0, 1'b0, 5'd3, 5'd0, 5'd6, 1'b1);
      drive_cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || issued_count !== cnt_before) begin
         tests_failed++;
         $display("[TB] FAIL flush: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, issued_count, cnt_before);
      end
      drive_cycle();
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      applyStimulus(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd9, 5'd3, 5'd13, 1'b1);
      drive_cycle();
      in_valid = 1'b0;
      tests_run++;
      if (ctrl_ALUopcode !== 5'd0 || out_wr_en !== 1'b0 || out_illegal !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL illegal_op: got op=%0d wr=%b ill=%b expected op=0 wr=0 ill=1", ctrl_ALUopcode, out_wr_en, out_illegal);
      end
      drive_cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         xm_wr_en  = $urandom_range(0, 1);  xm_rd_idx = $urandom_range(0, 7); xm_data = $urandom;
         mw_wr_en  = $urandom_range(0, 1);  mw_rd_idx = $urandom_range(0, 7); mw_data = $urandom;
         applyStimulus($urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
                       $urandom, $urandom_range(0, 1), $urandom_range(0, 12),
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
         drive_cycle();
      end
      flush = 1'b0; xm_wr_en = 1'b0; mw_wr_en = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      drive_cycle();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      applyStimulus(5'd5, 32'hCAFE_F00D, 5'd6, 32'h6, 32'h0, 1'b0, 5'd1, 5'd7, 5'd14, 1'b1);
      drive_cycle();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_valid: got %b expected 1", out_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_wr_en !== 1'b0 || data_operandA !== 32'd0 ||
          ctrl_ALUopcode !== 5'd0 || issued_count !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got v=%b wr=%b A=%h op=%0d cnt=%0d expected all 0",
                  out_valid, out_wr_en, data_operandA, ctrl_ALUopcode, issued_count);
      end
      sb.delete();
      exp_cnt = 0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      drive_cycle();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      xm_wr_en = 1'b0; xm_rd_idx = 5'd0; xm_data = 32'd0;
      mw_wr_en = 1'b0; mw_rd_idx = 5'd0; mw_data = 32'd0;
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      test_reset();
      test_basic_issue();
      test_bypass();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
